// File: rtl/output_buffer_read_transmit.sv
// Reads a buffered packet word-by-word from packet RAM and streams it as 9-bit bytes, then frees the buffer.
// First byte RAM_RD_LAT+2 cycles after descriptor ack; i_tx_ready=0 holds the byte pointer, no loss or duplication.
module output_buffer_read_transmit #(
    parameter int RAM_RD_LAT = 2,
    parameter int MAX_WORDS  = 128
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [8:0]   iv_bufid,
    input  logic         i_bufid_wr,
    output logic         o_bufid_ack,
    output logic [15:0]  ov_ram_raddr,
    output logic         o_ram_rd,
    input  logic [133:0] iv_ram_rdata,
    input  logic         i_tx_ready,
    output logic [8:0]   ov_data,
    output logic         o_data_wr,
    output logic [8:0]   ov_free_bufid,
    output logic         o_free_bufid_wr,
    output logic         o_tail_err_pulse,
    output logic [2:0]   ov_tx_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        SEND    = 3'd2,
        RELEASE = 3'd3
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(MAX_WORDS - 1);

    state_t                state;
    logic [8:0]            bufid;
    logic [6:0]            word_idx;
    logic [RAM_RD_LAT-1:0] rd_pipe;
    logic [127:0]          sh_word;
    logic [3:0]            sh_cnt;
    logic                  sh_first;
    logic                  sh_end;
    logic [133:0]          pf_word;
    logic                  pf_vld;

    logic         rd_done;
    logic [133:0] ld_word;
    logic [6:0]   ld_idx;
    logic         ld_tail;
    logic         ld_err;
    logic         ld_end;
    logic         sh_last;
    logic         send;
    logic         load;
    logic         unused_head_flag;

    // Only one RAM read is ever outstanding, so the pipe tail unambiguously marks its data.
    assign rd_done = rd_pipe[RAM_RD_LAT-1];
    assign ld_word = (state == FETCH) ? iv_ram_rdata : pf_word;
    assign ld_idx  = (state == FETCH) ? 7'd0 : word_idx + 7'd1;
    assign ld_tail = ld_word[133];
    assign ld_err  = !ld_tail && (ld_idx == LAST_IDX);
    assign ld_end  = ld_tail || ld_err;
    assign unused_head_flag = ld_word[132];

    assign sh_last = (sh_cnt == 4'd0);
    // Stall rather than drop if a word boundary is reached before its successor has arrived.
    assign send = (state == SEND) && i_tx_ready && !i_rst && !(sh_last && !sh_end && !pf_vld);
    assign load = (state == FETCH && rd_done) || (send && sh_last && !sh_end);

    assign o_bufid_ack = (state == IDLE) && i_bufid_wr && !i_rst;
    assign o_data_wr   = send;
    assign ov_data     = {sh_first || (sh_end && sh_last), sh_word[127:120]};
    assign ov_tx_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            bufid            <= '0;
            word_idx         <= '0;
            rd_pipe          <= '0;
            sh_word          <= '0;
            sh_cnt           <= '0;
            sh_first         <= 1'b0;
            sh_end           <= 1'b0;
            pf_word          <= '0;
            pf_vld           <= 1'b0;
            ov_ram_raddr     <= '0;
            o_ram_rd         <= 1'b0;
            ov_free_bufid    <= '0;
            o_free_bufid_wr  <= 1'b0;
            o_tail_err_pulse <= 1'b0;
        end else begin
            o_ram_rd         <= 1'b0;
            o_free_bufid_wr  <= 1'b0;
            ov_free_bufid    <= '0;
            o_tail_err_pulse <= 1'b0;
            for (int i = RAM_RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= o_ram_rd;

            case (state)
                IDLE: begin
                    if (i_bufid_wr) begin
                        bufid        <= iv_bufid;
                        word_idx     <= '0;
                        pf_vld       <= 1'b0;
                        o_ram_rd     <= 1'b1;
                        ov_ram_raddr <= {iv_bufid, 7'd0};
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_done) state <= SEND;
                end
                SEND: begin
                    if (rd_done) begin
                        pf_word <= iv_ram_rdata;
                        pf_vld  <= 1'b1;
                    end
                    if (send) begin
                        if (!sh_last) begin
                            sh_word  <= sh_word << 8;
                            sh_cnt   <= sh_cnt - 4'd1;
                            sh_first <= 1'b0;
                        end else if (sh_end) begin
                            state           <= RELEASE;
                            o_free_bufid_wr <= 1'b1;
                            ov_free_bufid   <= bufid;
                            sh_first        <= 1'b0;
                            sh_end          <= 1'b0;
                        end else begin
                            pf_vld <= 1'b0;
                        end
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Word load into the shift register, followed immediately by the prefetch of the next word.
            if (load) begin
                sh_word          <= ld_word[127:0];
                sh_cnt           <= ld_tail ? ld_word[131:128] : 4'hF;
                sh_first         <= (state == FETCH);
                sh_end           <= ld_end;
                word_idx         <= ld_idx;
                o_tail_err_pulse <= ld_err;
                if (!ld_end) begin
                    o_ram_rd     <= 1'b1;
                    ov_ram_raddr <= {bufid, ld_idx + 7'd1};
                end
            end
        end
    end

endmodule

// File: tb/tb_output_buffer_read_transmit.sv
// Scoreboard bench: stimulus pushes expected bytes/addresses/free ids, a negedge monitor pops and compares.
module tb_output_buffer_read_transmit;
    localparam int L = 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [8:0]   iv_bufid = '0;
    logic         i_bufid_wr = 1'b0;
    logic         o_bufid_ack;
    logic [15:0]  ov_ram_raddr;
    logic         o_ram_rd;
    logic [133:0] iv_ram_rdata = '0;
    logic         i_tx_ready = 1'b1;
    logic [8:0]   ov_data;
    logic         o_data_wr;
    logic [8:0]   ov_free_bufid;
    logic         o_free_bufid_wr;
    logic         o_tail_err_pulse;
    logic [2:0]   ov_tx_state;

    output_buffer_read_transmit #(.RAM_RD_LAT(L), .MAX_WORDS(128)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .iv_bufid(iv_bufid), .i_bufid_wr(i_bufid_wr),
        .o_bufid_ack(o_bufid_ack), .ov_ram_raddr(ov_ram_raddr), .o_ram_rd(o_ram_rd),
        .iv_ram_rdata(iv_ram_rdata), .i_tx_ready(i_tx_ready), .ov_data(ov_data),
        .o_data_wr(o_data_wr), .ov_free_bufid(ov_free_bufid), .o_free_bufid_wr(o_free_bufid_wr),
        .o_tail_err_pulse(o_tail_err_pulse), .ov_tx_state(ov_tx_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [8:0] d;
        bit         first;
        bit         last;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_free = 0;
    int n_err = 0;
    int n_bytes = 0;
    bit ready_mode = 1'b0;
    int ready_base = 0;

    logic [133:0] pkt [128];
    exp_t         exp_q [$];
    logic [15:0]  addr_q [$];
    logic [8:0]   free_q [$];
    int           first_cyc [$];
    int           last_cyc [$];
    int           free_cyc [$];
    bit           rd_v [0:8];
    logic [6:0]   rd_a [0:8];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM model: data for a read seen in cycle c is presented from mid-cycle c+L.
    always @(negedge i_clk) begin
        for (int i = 8; i > 0; i--) begin
            rd_v[i] = rd_v[i-1];
            rd_a[i] = rd_a[i-1];
        end
        rd_v[0] = o_ram_rd;
        rd_a[0] = ov_ram_raddr[6:0];
        iv_ram_rdata = rd_v[L] ? pkt[rd_a[L]] : {2'b11, 4'hA, {16{8'hEE}}};
    end

    // Downstream ready pattern: low for relative cycles 10..19 and every 3rd cycle after.
    always @(posedge i_clk) begin
        int rel;
        #1;
        rel = cyc - ready_base;
        if (ready_mode)
            i_tx_ready = !((rel >= 10 && rel <= 19) || (rel > 19 && (rel % 3) == 0));
        else
            i_tx_ready = 1'b1;
    end

    always @(negedge i_clk) begin
        if (o_data_wr) begin
            check("data_wr_needs_ready", i_tx_ready, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no output", ov_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_byte", ov_data, e.d);
                if (e.first) first_cyc.push_back(cyc);
                if (e.last) last_cyc.push_back(cyc);
                n_bytes++;
            end
        end
        if (o_free_bufid_wr) begin
            if (free_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_free: got 0x%0h, expected no pulse", ov_free_bufid);
            end else begin
                check("free_bufid", ov_free_bufid, free_q.pop_front());
            end
            free_cyc.push_back(cyc);
            n_free++;
        end
        if (o_ram_rd) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", ov_ram_raddr);
            end else begin
                check("ram_raddr", ov_ram_raddr, addr_q.pop_front());
            end
        end
        if (o_tail_err_pulse) n_err++;
    end

    task automatic build(input int nw, input int tc, input bit noterm, input int seed);
        for (int k = 0; k < 128; k++) begin
            logic [1:0]   fl;
            logic [3:0]   cnt;
            logic [127:0] dat;
            for (int j = 0; j < 16; j++) dat[127-8*j -: 8] = 8'(seed + 16*k + j);
            fl  = (k == 0) ? 2'b01 : 2'b00;
            cnt = 4'h5;
            if (!noterm && k == nw - 1) begin
                fl  = fl | 2'b10;
                cnt = 4'(tc);
            end
            pkt[k] = {fl, cnt, dat};
        end
    endtask

    task automatic expect_pkt(input logic [8:0] b, input int nw, input int tc, input bit noterm, input int seed);
        int n;
        n = noterm ? nw * 16 : (nw - 1) * 16 + tc + 1;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.first = (i == 0);
            e.last  = (i == n - 1);
            e.d     = {e.first | e.last, 8'(seed + i)};
            exp_q.push_back(e);
        end
        for (int k = 0; k < nw; k++) addr_q.push_back({b, 7'(k)});
        free_q.push_back(b);
    endtask

    task automatic clear_stamps();
        first_cyc.delete();
        last_cyc.delete();
        free_cyc.delete();
    endtask

    task automatic wait_ack(output int t);
        int n = 0;
        @(negedge i_clk);
        while (!o_bufid_ack && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check("ack_seen", o_bufid_ack, 1);
        t = cyc;
    endtask

    task automatic issue(input logic [8:0] b, output int t);
        @(posedge i_clk);
        #1;
        iv_bufid   = b;
        i_bufid_wr = 1'b1;
        wait_ack(t);
        @(posedge i_clk);
        #1;
        i_bufid_wr = 1'b0;
    endtask

    task automatic wait_free(input int target);
        int n = 0;
        while (n_free < target && n < 6000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("free_pulse_within_budget", n_free >= target, 1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_reads_left"}, addr_q.size(), 0);
        check({name, "_frees_left"}, free_q.size(), 0);
    endtask

    initial begin
        int t, t2, nf0, ne0, nb0, n;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_outputs", {o_bufid_ack, ov_ram_raddr, o_ram_rd, ov_data, o_data_wr,
                                ov_free_bufid, o_free_bufid_wr, o_tail_err_pulse, ov_tx_state}, 0);

        // 1: 64-byte packet, bufid 0x005, ready always high.
        clear_stamps();
        build(4, 15, 1'b0, 8'h10);
        expect_pkt(9'h005, 4, 15, 1'b0, 8'h10);
        issue(9'h005, t);
        wait_free(1);
        check("s1_first_byte_cycle", first_cyc[0], t + 2 + L);
        check("s1_last_byte_cycle", last_cyc[0], t + 2 + L + 63);
        check("s1_free_after_last", free_cyc[0], last_cyc[0] + 1);
        check_drained("s1");

        // 2: 61-byte packet at bufid 0x1FF, top of the address space.
        clear_stamps();
        build(4, 12, 1'b0, 8'h40);
        expect_pkt(9'h1FF, 4, 12, 1'b0, 8'h40);
        issue(9'h1FF, t);
        wait_free(2);
        check("s2_free_after_last", free_cyc[0], last_cyc[0] + 1);
        check_drained("s2");

        // 3: scenario 1 data with downstream backpressure.
        clear_stamps();
        build(4, 15, 1'b0, 8'h10);
        expect_pkt(9'h005, 4, 15, 1'b0, 8'h10);
        nf0 = n_free;
        issue(9'h005, t);
        ready_base = t;
        ready_mode = 1'b1;
        wait_free(nf0 + 1);
        repeat (10) @(posedge i_clk);
        #1;
        ready_mode = 1'b0;
        check("s3_single_free", n_free, nf0 + 1);
        check("s3_free_after_last", free_cyc[0], last_cyc[0] + 1);
        check_drained("s3");

        // 4: single-word packets back to back with the descriptor held high.
        clear_stamps();
        build(1, 3, 1'b0, 8'hA0);
        expect_pkt(9'h010, 1, 3, 1'b0, 8'hA0);
        expect_pkt(9'h011, 1, 3, 1'b0, 8'hA0);
        nf0 = n_free;
        @(posedge i_clk);
        #1;
        iv_bufid   = 9'h010;
        i_bufid_wr = 1'b1;
        wait_ack(t);
        @(posedge i_clk);
        #1;
        iv_bufid = 9'h011;
        wait_ack(t2);
        @(posedge i_clk);
        #1;
        i_bufid_wr = 1'b0;
        wait_free(nf0 + 2);
        check("s4_first_byte_cycle", first_cyc[0], t + 2 + L);
        check("s4_last_byte_cycle", last_cyc[0], t + 2 + L + 3);
        check("s4_second_ack_cycle", t2, last_cyc[0] + 2);
        check("s4_interpacket_gap", first_cyc[1] - last_cyc[0] - 1, L + 3);
        check_drained("s4");

        // 5: 128 words without a tail flag.
        clear_stamps();
        build(128, 0, 1'b1, 8'h03);
        expect_pkt(9'h07E, 128, 0, 1'b1, 8'h03);
        nf0 = n_free;
        ne0 = n_err;
        issue(9'h07E, t);
        wait_free(nf0 + 1);
        repeat (3) @(posedge i_clk);
        #1;
        check("s5_tail_err_once", n_err, ne0 + 1);
        check("s5_state_idle", ov_tx_state, 0);
        check_drained("s5");

        // 6: reset while byte 20 is presented, then a fresh packet.
        clear_stamps();
        build(4, 15, 1'b0, 8'h10);
        expect_pkt(9'h005, 4, 15, 1'b0, 8'h10);
        nb0 = n_bytes;
        nf0 = n_free;
        issue(9'h005, t);
        n = 0;
        while (n_bytes < nb0 + 20 && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("s6_reached_byte20", n_bytes, nb0 + 20);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("s6_outputs_after_reset", {o_bufid_ack, ov_ram_raddr, o_ram_rd, ov_data, o_data_wr,
                                         ov_free_bufid, o_free_bufid_wr, o_tail_err_pulse, ov_tx_state}, 0);
        @(posedge i_clk);
        #1;
        exp_q.delete();
        addr_q.delete();
        free_q.delete();
        repeat (20) @(posedge i_clk);
        #1;
        check("s6_no_free_after_abort", n_free, nf0);
        clear_stamps();
        build(2, 0, 1'b0, 8'h77);
        expect_pkt(9'h0AA, 2, 0, 1'b0, 8'h77);
        issue(9'h0AA, t);
        wait_free(nf0 + 1);
        check("s6_first_byte_cycle", first_cyc[0], t + 2 + L);
        check("s6_last_byte_cycle", last_cyc[0], t + 2 + L + 16);
        check_drained("s6");

        repeat (5) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
